// File: rtl/apb_bus_initiator.sv
// APB initiator: turns a single-outstanding request/response port into APB transfers.
// Optional ACCESS-phase timeout abort is compiled in with `define APB_TIMEOUT_EN.
module apb_bus_initiator #(
   parameter int W_ADDR         = 32,
   parameter int W_DATA         = 32,
   parameter int W_PADDR        = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [W_ADDR-1:0]  req_addr,
   input  logic               req_write,
   input  logic [W_DATA-1:0]  req_wdata,
   input  logic [W_DATA-1:0]  req_hartid,
   input  logic [W_ADDR-1:0]  req_pc,
   output logic               rsp_valid,
   output logic [W_DATA-1:0]  rsp_rdata,
   output logic               rsp_err,
   output logic [W_PADDR-1:0] paddr,
   output logic               psel,
   output logic               penable,
   output logic               pwrite,
   output logic [W_DATA-1:0]  pwdata,
   input  logic [W_DATA-1:0]  prdata,
   input  logic               pready,
   input  logic               pslverr,
   output logic [W_DATA-1:0]  phartid,
   output logic [W_ADDR-1:0]  pd_pc
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t              r_state;
   logic [W_PADDR-1:0]  r_paddr;
   logic                r_psel;
   logic                r_penable;
   logic                r_pwrite;
   logic [W_DATA-1:0]   r_pwdata;
   logic [W_DATA-1:0]   r_phartid;
   logic [W_ADDR-1:0]   r_pd_pc;
   logic                r_rsp_valid;
   logic [W_DATA-1:0]   r_rsp_rdata;
   logic                r_rsp_err;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb_bus_initiator: TIMEOUT_CYCLES must be at least 1");
   end

   if (W_ADDR > W_PADDR) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^req_addr[W_ADDR-1:W_PADDR];
   end

   function automatic logic [W_DATA-1:0] f_rsp_data(input logic wr,
                                                    input logic [W_DATA-1:0] rd);
      return wr ? '0 : rd;
   endfunction

`ifdef APB_TIMEOUT_EN
   localparam int W_CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int W_CNT     = (W_CNT_RAW < 8) ? 8 : ((W_CNT_RAW > 32) ? 32 : W_CNT_RAW);

   logic [W_CNT-1:0] r_cnt;
   logic             w_timeout;

   // The count holds the number of wait cycles already seen, so this cycle is the last allowed one.
   assign w_timeout = (r_cnt == W_CNT'(TIMEOUT_CYCLES - 1));
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_paddr     <= '0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_pwdata    <= '0;
         r_phartid   <= '0;
         r_pd_pc     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
         r_cnt       <= '0;
`endif
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_paddr   <= req_addr[W_PADDR-1:0];
                  r_pwrite  <= req_write;
                  r_pwdata  <= req_write ? req_wdata : '0;
                  r_phartid <= req_hartid;
                  r_pd_pc   <= req_pc;
                  r_psel    <= 1'b1;
                  r_penable <= 1'b0;
                  r_state   <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               r_penable <= 1'b1;
               r_state   <= ST_ACCESS;
`ifdef APB_TIMEOUT_EN
               r_cnt     <= '0;
`endif
            end
            ST_ACCESS: begin
               if (pready) begin
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= pslverr;
                  r_rsp_rdata <= f_rsp_data(r_pwrite, prdata);
                  r_state     <= ST_IDLE;
               end
`ifdef APB_TIMEOUT_EN
               else if (w_timeout) begin
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b1;
                  r_rsp_rdata <= '0;
                  r_state     <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
`endif
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready = (r_state == ST_IDLE);
   assign paddr     = r_paddr;
   assign psel      = r_psel;
   assign penable   = r_penable;
   assign pwrite    = r_pwrite;
   assign pwdata    = r_pwdata;
   assign phartid   = r_phartid;
   assign pd_pc     = r_pd_pc;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_bus_initiator.sv
// Directed bench for apb_bus_initiator: vector table of single transfers plus
// hand-written back-to-back and mid-transfer reset sequences.
module tb_apb_bus_initiator;

   localparam int W_ADDR  = 32;
   localparam int W_DATA  = 32;
   localparam int W_PADDR = 16;
`ifdef APB_TIMEOUT_EN
   localparam int TB_TIMEOUT = 4;
`else
   localparam int TB_TIMEOUT = 255;
`endif

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               req_valid = 1'b0;
   logic               req_ready;
   logic [W_ADDR-1:0]  req_addr = '0;
   logic               req_write = 1'b0;
   logic [W_DATA-1:0]  req_wdata = '0;
   logic [W_DATA-1:0]  req_hartid = '0;
   logic [W_ADDR-1:0]  req_pc = '0;
   logic               rsp_valid;
   logic [W_DATA-1:0]  rsp_rdata;
   logic               rsp_err;
   logic [W_PADDR-1:0] paddr;
   logic               psel;
   logic               penable;
   logic               pwrite;
   logic [W_DATA-1:0]  pwdata;
   logic [W_DATA-1:0]  prdata = '0;
   logic               pready = 1'b0;
   logic               pslverr = 1'b0;
   logic [W_DATA-1:0]  phartid;
   logic [W_ADDR-1:0]  pd_pc;

   apb_bus_initiator #(
      .W_ADDR(W_ADDR), .W_DATA(W_DATA), .W_PADDR(W_PADDR), .TIMEOUT_CYCLES(TB_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_write(req_write), .req_wdata(req_wdata), .req_hartid(req_hartid),
      .req_pc(req_pc), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .phartid(phartid), .pd_pc(pd_pc)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] hartid;
      logic [31:0] pc;
      logic [31:0] prdata;
      logic        err_in;
      int          waits;      // ACCESS cycles with pready=0 before pready=1
      logic        early_rdy;  // pready=1 during SETUP (must be ignored)
      int          exp_lat;    // cycles from acceptance to rsp_valid
      logic [15:0] exp_paddr;
      logic [31:0] exp_pwdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int          lat;
      int          viol;
      logic [50:0] exp_bus;
      string       tag;
      tag = $sformatf("v%0d", idx);
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = v.wr;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      req_hartid = v.hartid;
      req_pc     = v.pc;
      prdata     = v.prdata;
      pslverr    = v.err_in;
      pready     = 1'b0;
      check({tag, ".ready"}, {63'd0, req_ready}, 64'd1);
      @(negedge clk);
      // scramble request inputs so late sampling would show on the bus
      req_valid  = 1'b0;
      req_addr   = ~v.addr;
      req_wdata  = 32'h5A5A_5A5A;
      req_hartid = ~v.hartid;
      req_pc     = ~v.pc;
      req_write  = ~v.wr;
      exp_bus = {1'b1, 1'b0, v.wr, v.exp_paddr, v.exp_pwdata};
      check({tag, ".setup_bus"}, {13'd0, psel, penable, pwrite, paddr, pwdata}, {13'd0, exp_bus});
      check({tag, ".setup_side"}, {phartid, pd_pc}, {v.hartid, v.pc});
      pready = v.early_rdy;
      lat  = 0;
      viol = 0;
      exp_bus = {1'b1, 1'b1, v.wr, v.exp_paddr, v.exp_pwdata};
      for (int k = 2; k <= 40; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = k;
            break;
         end
         if (k == 2)
            check({tag, ".access_bus"}, {13'd0, psel, penable, pwrite, paddr, pwdata},
                  {13'd0, exp_bus});
         else if ({psel, penable, pwrite, paddr, pwdata} !== exp_bus ||
                  {phartid, pd_pc} !== {v.hartid, v.pc})
            viol++;
         pready = ((k - 2) >= v.waits);
      end
      check({tag, ".wait_stable"}, 64'(viol), 64'd0);
      check({tag, ".latency"}, 64'(lat), 64'(v.exp_lat));
      check({tag, ".rdata"}, {32'd0, rsp_rdata}, {32'd0, v.exp_rdata});
      check({tag, ".err"}, {63'd0, rsp_err}, {63'd0, v.exp_err});
      check({tag, ".post_bus"}, {13'd0, psel, penable, pwrite, paddr, pwdata},
            {13'd0, 2'b00, v.wr, v.exp_paddr, v.exp_pwdata});
      pready  = 1'b0;
      pslverr = 1'b0;
      @(negedge clk);
      check({tag, ".pulse_end"}, {30'd0, rsp_valid, req_ready, rsp_rdata}, {30'd0, 2'b01, v.exp_rdata});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int rises, gap, pulses, side_bad, quiet_bad;
      logic prev_psel;

      // Fields: wr, addr, wdata, hartid, pc, prdata, err_in, waits, early_rdy,
      //         exp_lat, exp_paddr, exp_pwdata, exp_rdata, exp_err
      vecs.push_back('{1'b1, 32'h0000_0010, 32'h0000_03E8, 32'd2, 32'h8000_0100, 32'hAAAA_5555,
                       1'b0, 1, 1'b0, 4, 16'h0010, 32'h0000_03E8, 32'h0, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0008, 32'hFFFF_FFFF, 32'd1, 32'h8000_0200, 32'h1234_5678,
                       1'b0, 0, 1'b0, 3, 16'h0008, 32'h0, 32'h1234_5678, 1'b0});
`ifdef APB_TIMEOUT_EN
      vecs.push_back('{1'b0, 32'h0001_0024, 32'h1111_2222, 32'd3, 32'h8000_0300, 32'hDEAD_BEEF,
                       1'b1, 5, 1'b0, 6, 16'h0024, 32'h0, 32'h0, 1'b1});
`else
      vecs.push_back('{1'b0, 32'h0001_0024, 32'h1111_2222, 32'd3, 32'h8000_0300, 32'hDEAD_BEEF,
                       1'b1, 5, 1'b0, 8, 16'h0024, 32'h0, 32'hDEAD_BEEF, 1'b1});
`endif
      vecs.push_back('{1'b1, 32'h0000_0004, 32'hCAFE_F00D, 32'd5, 32'h8000_0400, 32'h3333_4444,
                       1'b1, 2, 1'b1, 5, 16'h0004, 32'hCAFE_F00D, 32'h0, 1'b1});
`ifdef APB_TIMEOUT_EN
      vecs.push_back('{1'b0, 32'h0000_0030, 32'h0, 32'd6, 32'h8000_0500, 32'h7777_7777,
                       1'b0, 100, 1'b0, 6, 16'h0030, 32'h0, 32'h0, 1'b0 | 1'b1});
`endif

      // reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_ready", {63'd0, req_ready}, 64'd1);
      check("rst_ctrl", {59'd0, psel, penable, pwrite, rsp_valid, rsp_err}, 64'd0);
      check("rst_bus", {16'd0, paddr, pwdata}, 64'd0);
      check("rst_side", {phartid, pd_pc}, 64'd0);
      check("rst_rdata", {32'd0, rsp_rdata}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_idle", {61'd0, req_ready, psel, rsp_valid}, 64'd4);

      foreach (vecs[i]) run_vec(vecs[i], i);

      // back-to-back writes with req_valid held high
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_addr   = 32'h0000_0000;
      req_wdata  = 32'h0000_0011;
      req_hartid = 32'd0;
      req_pc     = 32'h8000_1000;
      pready     = 1'b0;
      pslverr    = 1'b0;
      rises = 0; gap = 0; pulses = 0; side_bad = 0;
      prev_psel = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (c == 0) begin
            req_addr   = 32'h0000_0004;
            req_wdata  = 32'h0000_0022;
            req_hartid = 32'd1;
            req_pc     = 32'h8000_1004;
         end
         if (psel && !prev_psel) rises++;
         if (!psel && rises == 1) gap++;
         if (psel) begin
            if (phartid !== 32'(rises - 1)) side_bad++;
            if (pd_pc !== ((rises == 1) ? 32'h8000_1000 : 32'h8000_1004)) side_bad++;
            if (paddr !== ((rises == 1) ? 16'h0000 : 16'h0004)) side_bad++;
         end
         if (rsp_valid) pulses++;
         if (rises >= 2) req_valid = 1'b0;
         pready    = psel && penable;
         prev_psel = psel;
      end
      pready = 1'b0;
      check("b2b_rises", 64'(rises), 64'd2);
      check("b2b_gap", 64'(gap), 64'd1);
      check("b2b_pulses", 64'(pulses), 64'd2);
      check("b2b_sideband", 64'(side_bad), 64'd0);

      // reset asserted in the middle of ACCESS
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_addr   = 32'h0000_0040;
      req_hartid = 32'd7;
      req_pc     = 32'h8000_2000;
      prdata     = 32'h9999_0000;
      pready     = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("mid_pre_access", {62'd0, psel, penable}, 64'd3);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_async", {60'd0, psel, penable, rsp_valid, req_ready}, 64'd1);
      check("mid_rst_paddr", {48'd0, paddr}, 64'd0);
      @(negedge clk);
      rst    = 1'b0;
      pready = 1'b1;
      quiet_bad = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (rsp_valid || psel || penable || !req_ready) quiet_bad++;
      end
      pready = 1'b0;
      check("mid_rst_no_rsp", 64'(quiet_bad), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_bus_initiator.md
Name: apb_bus_initiator

Overview:
- APB initiator (requester) that converts a simple single-outstanding core-side request/response port into APB transfers for the example SoC peripheral bus, e.g. the RISC-V timer/IPI block.
- Drives paddr/psel/penable/pwrite/pwdata plus the phartid/pd_pc sideband, and waits on pready.
- Returns prdata/pslverr to the requester as a one-cycle response pulse.
- Holds exactly one transfer in flight.

Parameters:
W_ADDR, 32, width of core-side address and of the pd_pc sideband
W_DATA, 32, width of data and of the phartid sideband
W_PADDR, 16, APB address width; paddr = req_addr[W_PADDR-1:0]
TIMEOUT_CYCLES, 255, maximum ACCESS-phase cycles before abort (used only with the optional feature); must be at least 1

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  reset; one clock; reset is asynchronous and active-high
req_valid  in  1  request present
req_ready  out  1  initiator can accept; high only in IDLE
req_addr  in  W_ADDR  byte address
req_write  in  1  1 = write, 0 = read
req_wdata  in  W_DATA  write data
req_hartid  in  W_DATA  requesting hart ID
req_pc  in  W_ADDR  PC of the requesting instruction
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  W_DATA  read data; 0 for writes and aborts
rsp_err  out  1  slave error or timeout
paddr  out  W_PADDR  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  W_DATA  APB write data
prdata  in  W_DATA  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error
phartid  out  W_DATA  hart ID sideband, valid while psel
pd_pc  out  W_ADDR  PC sideband, valid while psel

Behaviour:
- Reset: all outputs are registered except req_ready, which decodes the state.
- Reset values: state=IDLE, so req_ready=1. psel, penable, pwrite, rsp_valid and rsp_err reset to 0. paddr, pwdata, phartid, pd_pc and rsp_rdata reset to 0.
- An asserted rst mid-transfer abandons the transfer immediately and issues no rsp_valid.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: req_ready=1.
  - On req_valid, capture addr, write, hartid and pc; pwdata = req_wdata if write, else 0.
  - Set psel=1, penable=0 and go to SETUP.
- SETUP: lasts exactly one cycle. Set penable=1 and go to ACCESS.
- ACCESS: sample pready each cycle.
  - When pready=1: psel=0, penable=0, rsp_valid=1 next cycle, rsp_err=pslverr, rsp_rdata = write ? 0 : prdata, then go to IDLE.
  - While pready=0: hold all APB outputs stable.
- rsp_valid is high for exactly one cycle and has no backpressure. rsp_rdata/rsp_err hold until the next response.
- Latency: request accepted in cycle N gives psel high N+1..., penable high N+2..., and pready sampled from N+2.
  - With a slave registering pready one cycle late (pready seen N+3), rsp_valid is at N+4.
- Back-to-back: a request presented in the rsp_valid cycle is accepted; psel rises the next cycle.
  - This guarantees at least one cycle with psel=0 between transfers, so slaves that wait for penable to drop return to idle.
- paddr, pwrite, phartid and pd_pc hold their last values after the transfer. pwdata holds as well.
- pready or pslverr outside ACCESS are ignored.
- req_valid outside IDLE is ignored; req_ready=0 then.

Optional Feature:
APB_TIMEOUT_EN:
- Defined: an 8..32-bit counter (width from TIMEOUT_CYCLES) clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
- When the count reaches TIMEOUT_CYCLES with pready still 0, the transfer aborts:
  - psel=0 and penable=0;
  - rsp_valid=1 next cycle with rsp_err=1 and rsp_rdata=0;
  - the FSM returns to IDLE.
- pready=1 on the same cycle as the limit wins and completes normally.
- Undefined: no counter; ACCESS waits indefinitely for pready.

Test Plan:
- Write: req addr 0x0010, wdata 0x000003E8, write=1, slave pready one cycle late. Required response:
  - psel/penable/pwrite/paddr=0x0010/pwdata=0x3E8 are seen on the bus;
  - rsp_valid 4 cycles after acceptance with rsp_err=0 and rsp_rdata=0.
- Read: req addr 0x0008 read, slave returns prdata=0x12345678 with pready in the first ACCESS cycle. Required response: rsp_valid 3 cycles after acceptance with rsp_rdata=0x12345678; pwdata=0 during the transfer.
- Back-to-back: hold req_valid high for two writes to 0x0000 then 0x0004 with hartid 0 and 1. Required response:
  - exactly one psel=0 cycle between the transfers;
  - phartid/pd_pc match each request while psel=1;
  - two rsp_valid pulses.
- Wait states and error: slave holds pready=0 for 5 ACCESS cycles, then pready=1 and pslverr=1. Required response:
  - APB outputs stay stable through the wait;
  - one rsp_valid pulse with rsp_err=1.
- Reset mid-ACCESS: assert rst while penable=1. Required response:
  - psel, penable and rsp_valid drop to 0 asynchronously and req_ready=1;
  - no response follows after rst deasserts.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=4 and pready tied 0. Required response: abort after 4 ACCESS cycles with rsp_valid=1, rsp_err=1, rsp_rdata=0, then IDLE with req_ready=1.
